// File: rtl/reg_shifter_pkg.sv
// reg_shifter_pkg: default WIDTH/DEPTH/AW parameters and the shift_dir encodings (SHIFT_LEFT=0, SHIFT_RIGHT=1) shared by every reg_shifter file
package reg_shifter_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW = 3;
  localparam int DEF_DEPTH = 2 ** DEF_AW;
  typedef enum logic {SHIFT_LEFT = 1'b0, SHIFT_RIGHT = 1'b1} shift_dir_e;
endpackage

// File: rtl/reg_shifter_if.sv
// reg_shifter_if: bus bundle; master drives wr/shift/shift_dir/wr_addr/d_in/rd_addr_a/rd_addr_b, slave returns d_out_a/d_out_b
interface reg_shifter_if import reg_shifter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW = DEF_AW
) ();
  logic wr;
  logic shift;
  logic shift_dir;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out_a;
  logic [WIDTH-1:0] d_out_b;
  modport master (
    output wr, shift, shift_dir, rd_addr_a, rd_addr_b, wr_addr, d_in,
    input d_out_a, d_out_b
  );
  modport slave (
    input wr, shift, shift_dir, rd_addr_a, rd_addr_b, wr_addr, d_in,
    output d_out_a, d_out_b
  );
endinterface

// File: rtl/reg_shifter_shift_unit.sv
// shift_unit: combinational one-bit logical shift; in value, dir (SHIFT_LEFT/SHIFT_RIGHT) -> out result, vacated bit filled with 0
module shift_unit import reg_shifter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);
  always_comb result = (dir == SHIFT_RIGHT) ? value >> 1 : value << 1;
endmodule

// File: rtl/reg_shifter.sv
// reg_shifter: DEPTH x WIDTH register file with write/shift at wr_addr and two async read ports; in clk, reset (async high), bus (slave)
module reg_shifter import reg_shifter_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = DEF_AW
) (
  input logic            clk,
  input logic            reset,
  reg_shifter_if.slave   bus
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt;
  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .value  (regs[bus.wr_addr]),
    .dir    (bus.shift_dir),
    .result (shifted)
  );
  always_comb nxt = bus.wr ? bus.d_in : shifted;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.wr || bus.shift) begin
      regs[bus.wr_addr] <= nxt;
    end
  end
  assign bus.d_out_a = regs[bus.rd_addr_a];
  assign bus.d_out_b = regs[bus.rd_addr_b];
endmodule

// File: tb/tb_reg_shifter.sv
// tb_reg_shifter: directed self-checking bench for reg_shifter with an expected-value queue scoreboard
module tb_reg_shifter;
  import reg_shifter_pkg::*;
  logic clk = 1'b0;
  logic reset;
  reg_shifter_if #(.WIDTH(16), .AW(3)) bus ();
  reg_shifter #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  logic [15:0] model [8];
  logic [15:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  task automatic cmp(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask
  task automatic check(input string tag, input logic [2:0] aa, input logic [2:0] ab,
                       input logic [15:0] ea, input logic [15:0] eb);
    bus.rd_addr_a = aa;
    bus.rd_addr_b = ab;
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    #1;
    cmp({tag, "_a"}, bus.d_out_a);
    cmp({tag, "_b"}, bus.d_out_b);
  endtask
  task automatic step(input logic w, input logic s, input logic dir,
                      input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.wr = w;
    bus.shift = s;
    bus.shift_dir = dir;
    bus.wr_addr = a;
    bus.d_in = d;
    @(posedge clk);
    if (!reset) model[a] = w ? d : s ? (dir ? model[a] >> 1 : model[a] << 1) : model[a];
    #1;
    bus.wr = 1'b0;
    bus.shift = 1'b0;
  endtask
  initial begin
    foreach (model[i]) model[i] = '0;
    reset = 1'b1;
    bus.wr = 1'b0;
    bus.shift = 1'b0;
    bus.shift_dir = SHIFT_LEFT;
    bus.wr_addr = '0;
    bus.d_in = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    #12;
    check("reset_state", 3'd0, 3'd7, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd0, 16'h004B);
    step(1'b0, 1'b1, SHIFT_LEFT, 3'd0, 16'h0000);
    check("r0_shl", 3'd0, 3'd0, 16'h0096, 16'h0096);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd1, 16'h0037);
    step(1'b0, 1'b1, SHIFT_RIGHT, 3'd1, 16'h0000);
    check("r1_shr", 3'd1, 3'd0, 16'h001B, 16'h0096);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd2, 16'h8001);
    step(1'b0, 1'b1, SHIFT_LEFT, 3'd2, 16'h0000);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd3, 16'h8001);
    step(1'b0, 1'b1, SHIFT_RIGHT, 3'd3, 16'h0000);
    check("msb_lsb_drop", 3'd2, 3'd3, 16'h0002, 16'h4000);
    step(1'b1, 1'b1, SHIFT_LEFT, 3'd4, 16'h1234);
    check("wr_priority", 3'd4, 3'd0, 16'h1234, 16'h0096);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd5, 16'h0001);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, SHIFT_LEFT, 3'd5, 16'h0000);
    check("shl_x4", 3'd5, 3'd4, 16'h0010, 16'h1234);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, SHIFT_RIGHT, 3'd5, 16'h0000);
    check("shr_x3", 3'd5, 3'd1, 16'h0002, 16'h001B);
    @(negedge clk);
    bus.wr = 1'b1;
    bus.wr_addr = 3'd5;
    bus.d_in = 16'hABCD;
    check("no_bypass", 3'd5, 3'd5, 16'h0002, 16'h0002);
    @(posedge clk);
    model[5] = 16'hABCD;
    #1;
    bus.wr = 1'b0;
    check("post_edge", 3'd5, 3'd2, 16'hABCD, 16'h0002);
    step(1'b0, 1'b0, SHIFT_RIGHT, 3'd5, 16'hFFFF);
    check("idle_hold", 3'd5, 3'd3, 16'hABCD, 16'h4000);
    for (int i = 0; i < 8; i++) check("isolation", 3'(i), 3'(7 - i), model[i], model[7 - i]);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd0, 16'h0000);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd1, 16'h0000);
    check("zero_wr", 3'd0, 3'd1, 16'h0000, 16'h0000);
    check("zero_wr_others", 3'd2, 3'd4, 16'h0002, 16'h1234);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd6, 16'h1111);
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd7, 16'h2222);
    check("preload", 3'd6, 3'd7, 16'h1111, 16'h2222);
    @(negedge clk);
    #1;
    reset = 1'b1;
    foreach (model[i]) model[i] = '0;
    #1;
    for (int i = 0; i < 4; i++) check("async_reset", 3'(i), 3'(i + 4), 16'h0000, 16'h0000);
    step(1'b1, 1'b1, SHIFT_LEFT, 3'd6, 16'hFFFF);
    check("wr_in_reset", 3'd6, 3'd7, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, SHIFT_LEFT, 3'd7, 16'h5A5A);
    check("resume", 3'd7, 3'd6, 16'h5A5A, 16'h0000);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_shifter.md
REG_SHIFTER -- requirements
Module: reg_shifter

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of registers.
REQ-003 Parameter AW, default 3, address width; DEPTH SHALL equal 2**AW.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr  input  1  write enable for the register at wr_addr.
REQ-007 shift_dir  input  1  shift direction: 0 = left, 1 = right.
REQ-008 shift  input  1  shift enable for the register at wr_addr.
REQ-009 rd_addr_a  input  AW  read address, port A.
REQ-010 rd_addr_b  input  AW  read address, port B.
REQ-011 wr_addr  input  AW  target address for both write and shift.
REQ-012 d_in  input  WIDTH  write data.
REQ-013 d_out_a  output  WIDTH  contents of register rd_addr_a.
REQ-014 d_out_b  output  WIDTH  contents of register rd_addr_b.

Function
REQ-015 Storage SHALL be DEPTH registers of WIDTH bits.
REQ-016 Reads SHALL be combinational: d_out_a = reg[rd_addr_a] and d_out_b = reg[rd_addr_b], zero-cycle latency, both ports independent, same address allowed on both.
REQ-017 On a rising clk with wr=1: reg[wr_addr] <= d_in; the new value SHALL be visible on read ports after that edge.
REQ-018 On a rising clk with wr=0, shift=1, shift_dir=0: reg[wr_addr] <= reg[wr_addr] << 1, LSB filled with 0, MSB discarded.
REQ-019 On a rising clk with wr=0, shift=1, shift_dir=1: reg[wr_addr] <= reg[wr_addr] >> 1 (logical), MSB filled with 0, LSB discarded.
REQ-020 Shift amount SHALL be exactly one bit per enabled cycle; a shift held for N cycles SHALL shift N bits.
REQ-021 wr=1 and shift=1 in the same cycle: write SHALL take priority; no shift occurs.
REQ-022 wr=0 and shift=0: all registers SHALL hold.
REQ-023 Only reg[wr_addr] SHALL change in any cycle; all other registers hold.
REQ-024 No write-to-read bypass: reading the address being written in the same cycle SHALL return the pre-edge value until the edge.
REQ-025 X/Z on wr_addr is not supported; behaviour then is unspecified.

Reset
REQ-026 reset=1 SHALL asynchronously clear all registers to 0, so d_out_a = d_out_b = 0 without waiting for clk.
REQ-027 While reset=1, wr and shift SHALL be ignored.
REQ-028 Reset asserted mid-sequence SHALL discard any pending update; operation resumes on the first rising clk after reset deasserts.

Structure
REQ-029 A shared package SHALL hold WIDTH/DEPTH/AW defaults and shift_dir encodings (SHIFT_LEFT=0, SHIFT_RIGHT=1).
REQ-030 One sub-module, shift_unit (combinational: value, dir -> value shifted by one), SHALL compute the shift result; reg_shifter holds the register array, priority mux and read muxes.

Verification
REQ-031 Write 0x004B to r0, then shift=1, shift_dir=0, wr_addr=0 for one cycle -> r0 = 0x0096 on d_out_a with rd_addr_a=0.
REQ-032 Write 0x0037 to r1, then shift=1, shift_dir=1, wr_addr=1 -> r1 = 0x001B on d_out_a with rd_addr_a=1; r0 unchanged on d_out_b.
REQ-033 r2 = 0x8001, shift left one cycle -> 0x0002; r3 = 0x8001, shift right one cycle -> 0x4000.
REQ-034 wr=1, shift=1, wr_addr=4, d_in=0x1234 -> r4 = 0x1234 (write wins, no shift).
REQ-035 Registers loaded with non-zero values, reset pulsed between clock edges -> d_out_a and d_out_b read 0 immediately for all addresses.
REQ-036 Write d_in=0x0000 to r0 then r1 on consecutive cycles -> both read 0; other registers unchanged.
